uart_tx_top: RTL and testbench
==============================

// Module: uart_tx_top
// PURPOSE
//  UART transmitter top level: baud-rate generator plus 8N1 serial TX state machine.
//  - Accepts a parallel byte on a one-cycle load strobe.
//  - Shifts the byte out LSB-first on tx_out at one of four selectable baud rates.
//  - Reports busy status to the host logic.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock frequency in Hz
//  BAUD0      9600         rate for baudsel=2'b00
//  BAUD1      19200        rate for baudsel=2'b01
//  BAUD2      57600        rate for baudsel=2'b10
//  BAUD3      115200       rate for baudsel=2'b11
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-low reset
//  baudsel    in   2  baud rate select, sampled at load
//  d_in       in   8  byte to transmit, sampled at load
//  load       in   1  start request, one-cycle strobe, active high
//  tx_out     out  1  serial line; idles high
//  tx_status  out  1  1 = frame in progress (busy), 0 = idle/ready
// BEHAVIOUR
//  Clock and reset:
//  - Single clock domain (clk); asynchronous active-low reset (rst).
//  - Reset values: tx_out=1, tx_status=0, FSM=IDLE, counters=0, shift reg=0.
//  - Reset asserted mid-frame aborts the frame immediately; line returns high.
//  Bit timing:
//  - Divisor DIV = round(CLK_FREQ/BAUDn). At defaults: 10417, 5208, 1736, 868 clocks/bit.
//  - Bit-period counter runs 0..DIV-1; restarts at 0 when a frame is accepted.
//  - Every bit, start and stop included, lasts exactly DIV clocks.
//  Load and latching:
//  - In IDLE, load=1 on a rising edge latches d_in, latches the baudsel divisor, enters START.
//  - On the same edge, tx_out=0 and tx_status=1 (visible the cycle after the load edge).
//  - load while busy is ignored; no queueing.
//  - Changes to d_in/baudsel after the load edge do not affect the current frame.
//  FSM states:
//  - IDLE:  tx_out=1. Exit to START on load.
//  - START: tx_out=0 for DIV clocks, then DATA.
//  - DATA:  bits d[0]..d[7], LSB first, DIV clocks each; 3-bit index. After bit 7, STOP.
//  - STOP:  tx_out=1 for DIV clocks, then IDLE; tx_status=0 the cycle STOP ends.
//  Frame timing:
//  - Frame length = 10*DIV clocks from the load edge to tx_status falling.
//  - load coinciding with the final STOP cycle is ignored; load one cycle later starts a new frame.
//  - tx_out is registered (glitch-free).
//  - load held high for several cycles starts exactly one frame.
//  - load still high on return to IDLE starts a new frame.
// TESTING
//  - Reset: hold rst=0 -> tx_out=1, tx_status=0; no activity while load=0 after release.
//  - 9600 baud, d_in=8'h0F, 1-cycle load -> tx_out = 0,1,1,1,1,0,0,0,0,1, each 10417 clks;
//    tx_status high for 104170 clks.
//  - 115200 baud, d_in=8'hA5 -> bits 0,1,0,1,0,0,1,0,1,1 at 868 clks each.
//  - load pulse mid-frame (d_in=8'hFF) -> ignored; first frame bits unchanged; no second frame.
//  - Change baudsel/d_in one cycle after load -> frame still uses the latched values.
//  - Assert rst during DATA -> tx_out=1, tx_status=0 immediately; next load sends a full clean frame.

Source files
------------

// File: rtl/uart_tx_top.sv
// UART transmitter: baud divisor select plus 8N1 serial shift FSM.
// A byte loaded while idle is sent LSB first as start, 8 data, stop bits,
// each bit lasting exactly DIV clocks of the divisor latched at load time.
module uart_tx_top #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD0    = 9600,
  parameter int unsigned BAUD1    = 19200,
  parameter int unsigned BAUD2    = 57600,
  parameter int unsigned BAUD3    = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baudsel,
  input  logic [7:0] d_in,
  input  logic       load,
  output logic       tx_out,
  output logic       tx_status
);

  // Rounded clocks-per-bit for each selectable rate.
  localparam int unsigned DIV0 = (CLK_FREQ + BAUD0 / 2) / BAUD0;
  localparam int unsigned DIV1 = (CLK_FREQ + BAUD1 / 2) / BAUD1;
  localparam int unsigned DIV2 = (CLK_FREQ + BAUD2 / 2) / BAUD2;
  localparam int unsigned DIV3 = (CLK_FREQ + BAUD3 / 2) / BAUD3;
  localparam int unsigned DMAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned DMAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned DMAX   = (DMAX01 > DMAX23) ? DMAX01 : DMAX23;
  localparam int unsigned CW     = $clog2(DMAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] div_q;
  logic [7:0]    shift_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] div_sel_s;
  logic          bit_end_s;

  // Divisor chosen by baudsel; only consulted on the load edge.
  always_comb begin
    div_sel_s = CW'(DIV0);
    case (baudsel)
      2'b00:   div_sel_s = CW'(DIV0);
      2'b01:   div_sel_s = CW'(DIV1);
      2'b10:   div_sel_s = CW'(DIV2);
      2'b11:   div_sel_s = CW'(DIV3);
      default: div_sel_s = CW'(DIV0);
    endcase
  end

  // Last clock of the current bit period.
  always_comb begin
    bit_end_s = 1'b0;
    if (cnt_q == (div_q - CW'(1))) begin
      bit_end_s = 1'b1;
    end else begin
      bit_end_s = 1'b0;
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      shift_q   <= 8'h00;
      idx_q     <= 3'd0;
      tx_out    <= 1'b1;
      tx_status <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_out    <= 1'b1;
          tx_status <= 1'b0;
          if (load) begin
            state_q   <= START;
            shift_q   <= d_in;
            div_q     <= div_sel_s;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            tx_out    <= 1'b0;
            tx_status <= 1'b1;
          end
        end
        START: begin
          if (bit_end_s) begin
            cnt_q   <= '0;
            state_q <= DATA;
            tx_out  <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_out  <= 1'b1;
            end else begin
              // Next data bit becomes the new LSB of the shifter.
              idx_q   <= idx_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_out  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            cnt_q     <= '0;
            state_q   <= IDLE;
            tx_status <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          tx_out    <= 1'b1;
          tx_status <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top with a 1 MHz clock so frames stay short.
// Divisors at this clock: round(1e6/9600)=104, /19200=52, /57600=17, /115200=9.
module tb_uart_tx_top;

  localparam int D0 = 104;
  localparam int D1 = 52;
  localparam int D2 = 17;
  localparam int D3 = 9;

  logic       clk;
  logic       rst;
  logic [1:0] baudsel;
  logic [7:0] d_in;
  logic       load;
  logic       tx_out;
  logic       tx_status;

  int n_checks;
  int n_fail;

  uart_tx_top #(
    .CLK_FREQ(1_000_000),
    .BAUD0   (9600),
    .BAUD1   (19200),
    .BAUD2   (57600),
    .BAUD3   (115200)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .baudsel  (baudsel),
    .d_in     (d_in),
    .load     (load),
    .tx_out   (tx_out),
    .tx_status(tx_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Caller has raised load at a negedge. Waits for the load edge, then checks
  // every symbol at its first and last clock and the exact busy window.
  // hold:  negedge index at which load is dropped.
  // mode 1: change d_in/baudsel right after the load edge.
  // mode 2: pulse load with d_in=FF in the middle of the data bits.
  // mode 3: raise load during the final STOP cycle (must be ignored).
  task automatic frame(input string tag, input logic [9:0] sym, input int div,
                       input int hold, input int mode);
    @(posedge clk);
    for (int t = 1; t <= 10 * div + 1; t++) begin
      @(negedge clk);
      if (t == hold) load = 1'b0;
      if (mode == 1 && t == 1) begin
        d_in = ~d_in;
        baudsel = ~baudsel;
      end
      if (mode == 2 && t == 3 * div + 5) begin
        d_in = 8'hFF;
        load = 1'b1;
      end
      if (mode == 2 && t == 3 * div + 6) load = 1'b0;
      if (mode == 3 && t == 10 * div) load = 1'b1;
      if (mode == 3 && t == 10 * div + 1) load = 1'b0;
      if (t <= 10 * div) begin
        if ((t - 1) % div == 0 || t % div == 0)
          chk($sformatf("%s_bit%0d_t%0d", tag, (t - 1) / div, t), 32'(tx_out),
              32'(sym[(t - 1) / div]));
      end
      if (t == 10 * div) chk({tag, "_busy_last"}, 32'(tx_status), 32'd1);
      if (t == 10 * div + 1) begin
        chk({tag, "_busy_fall"}, 32'(tx_status), 32'd0);
        chk({tag, "_idle_line"}, 32'(tx_out), 32'd1);
      end
    end
  endtask

  // Line must stay idle for n cycles.
  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_status !== 1'b0 || tx_out !== 1'b1) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    load     = 1'b0;
    d_in     = 8'h00;
    baudsel  = 2'b00;

    // Reset values while held.
    repeat (3) @(negedge clk);
    chk("rst_tx_out", 32'(tx_out), 32'd1);
    chk("rst_status", 32'(tx_status), 32'd0);
    rst = 1'b1;
    idle_check("post_rst_idle", 20);

    // 9600 baud, 0x0F: 0,1,1,1,1,0,0,0,0,1.
    d_in = 8'h0F; baudsel = 2'b00; load = 1'b1;
    frame("b9600_0F", 10'b1000011110, D0, 1, 0);
    idle_check("b9600_idle", 5);

    // 115200 baud, 0xA5: 0,1,0,1,0,0,1,0,1,1.
    d_in = 8'hA5; baudsel = 2'b11; load = 1'b1;
    frame("b115k_A5", 10'b1101001010, D3, 1, 0);

    // 19200 baud, 0x3C, load held four cycles -> one frame only.
    @(negedge clk);
    d_in = 8'h3C; baudsel = 2'b01; load = 1'b1;
    frame("b19k_3C_hold", 10'b1001111000, D1, 4, 0);
    idle_check("hold_one_frame", 2 * D1);

    // 57600 baud, 0x81, with load ignored in final STOP cycle.
    d_in = 8'h81; baudsel = 2'b10; load = 1'b1;
    frame("b57k_81", 10'b1100000010, D2, 1, 3);
    idle_check("stop_load_ignored", 3 * D2);

    // Mid-frame load with 0xFF is ignored; no second frame.
    d_in = 8'h5A; baudsel = 2'b11; load = 1'b1;
    frame("midload_5A", 10'b1010110100, D3, 1, 2);
    idle_check("midload_no_frame", 3 * D3);

    // Inputs change one cycle after load; frame uses latched 0x5A at 115200.
    d_in = 8'h5A; baudsel = 2'b11; load = 1'b1;
    frame("latched_5A", 10'b1010110100, D3, 1, 1);

    // Back-to-back: load one cycle after STOP ends starts a new frame.
    d_in = 8'hA5; baudsel = 2'b11; load = 1'b1;
    frame("b2b_A5", 10'b1101001010, D3, 1, 0);

    // Reset during DATA aborts immediately, then a clean frame follows.
    @(negedge clk);
    d_in = 8'h00; baudsel = 2'b10; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3 * D2) @(negedge clk);
    chk("pre_abort_busy", 32'(tx_status), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_tx_out", 32'(tx_out), 32'd1);
    chk("abort_status", 32'(tx_status), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_check("abort_idle", 10);
    d_in = 8'h0F; baudsel = 2'b10; load = 1'b1;
    frame("after_abort_0F", 10'b1000011110, D2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
